// File: rtl/mem_stream_reader.sv
// Streams a block of words out of a synchronous-read RAM through a 2-entry skid FIFO with valid/ready flow control.
// Optional: define CHECKSUM_EN to add a running XOR checksum of accepted words.
module mem_stream_reader #(
   parameter int unsigned data_width = 32,
   parameter int unsigned addr_width = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [addr_width-1:0] start_addr,
   input  logic [addr_width:0]   count,
   output logic [addr_width-1:0] read_address,
   input  logic [data_width-1:0] ram_dout,
   output logic [data_width-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  busy,
   output logic                  done
`ifdef CHECKSUM_EN
   ,
   output logic [data_width-1:0] checksum
`endif
);

   localparam int unsigned CNT_W = addr_width + 1;

   typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

   state_t                  state;
   state_t                  state_next;
   logic                    busy_next;
   logic                    done_next;
   logic [CNT_W-1:0]        remaining;
   logic [data_width-1:0]   second;
   logic [1:0]              occ;
   logic                    in_flight;

   logic                    pop_c;
   logic                    start_c;
   logic                    issue_c;
   logic                    last_pop_c;
   logic [2:0]              pending_c;
   logic [1:0]              occ_next_c;

   assign pop_c      = out_valid && out_ready;
   assign start_c    = (state == IDLE) && start;
   // Words already buffered plus the one on its way, after this cycle's pop.
   assign pending_c  = 3'(occ) + 3'(in_flight) - 3'(pop_c);
   assign issue_c    = (state == RUN) && (remaining != '0) && (pending_c <= 3'd1);
   assign occ_next_c = 2'(occ + 2'(in_flight) - 2'(pop_c));
   assign last_pop_c = (state == FLUSH) && pop_c && (occ == 2'd1) && !in_flight;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_next;
         busy  <= busy_next;
         done  <= done_next;
      end
   end

   always_comb begin
      state_next = state;
      busy_next  = 1'b0;
      done_next  = 1'b0;
      case (state)
         IDLE:    if (start) state_next = (count != '0) ? RUN : DONE;
         RUN:     if (issue_c && (remaining == CNT_W'(1))) state_next = FLUSH;
         FLUSH:   if (last_pop_c) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
      busy_next = (state_next == RUN) || (state_next == FLUSH);
      done_next = (state_next == DONE);
   end

   // Address/count tracking and the 2-entry FIFO; out_data is the FIFO head.
   always_ff @(posedge clk) begin
      if (reset) begin
         read_address <= '0;
         remaining    <= '0;
         in_flight    <= 1'b0;
         occ          <= 2'd0;
         out_valid    <= 1'b0;
         out_data     <= '0;
         second       <= '0;
      end else begin
         if (start_c) begin
            read_address <= start_addr;
            remaining    <= count;
         end else if (issue_c) begin
            read_address <= addr_width'(read_address + addr_width'(1));
            remaining    <= CNT_W'(remaining - CNT_W'(1));
         end
         in_flight <= issue_c;

         case ({in_flight, pop_c})
            2'b10: begin
               if (occ == 2'd0) out_data <= ram_dout;
               else             second   <= ram_dout;
            end
            2'b01: begin
               if (occ == 2'd2) out_data <= second;
            end
            2'b11: begin
               if (occ == 2'd1) begin
                  out_data <= ram_dout;
               end else begin
                  out_data <= second;
                  second   <= ram_dout;
               end
            end
            default: ;
         endcase
         occ       <= occ_next_c;
         out_valid <= (occ_next_c != 2'd0);
      end
   end

`ifdef CHECKSUM_EN
   always_ff @(posedge clk) begin
      if (reset || start_c) checksum <= '0;
      else if (pop_c)       checksum <= checksum ^ out_data;
   end
`endif

endmodule

// File: tb/tb_mem_stream_reader.sv
// Bench for mem_stream_reader: RAM model, queue-based stream model, directed vectors.
module tb_mem_stream_reader;

   localparam int unsigned DW    = 32;
   localparam int unsigned AW    = 4;
   localparam int unsigned DEPTH = 16;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [AW-1:0] start_addr;
   logic [AW:0]   count;
   logic [AW-1:0] read_address;
   logic [DW-1:0] ram_dout;
   logic [DW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic          busy;
   logic          done;
`ifdef CHECKSUM_EN
   logic [DW-1:0] checksum;
`endif

   logic [DW-1:0] mem [DEPTH];
   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   always @(posedge clk) ram_dout <= mem[read_address];

   mem_stream_reader #(.data_width(DW), .addr_width(AW)) dut (
      .clk(clk),
      .reset(reset),
      .start(start),
      .start_addr(start_addr),
      .count(count),
      .read_address(read_address),
      .ram_dout(ram_dout),
      .out_data(out_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .busy(busy),
      .done(done)
`ifdef CHECKSUM_EN
      ,
      .checksum(checksum)
`endif
   );

   task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Stream model: a block is the list of words mem[start_addr+i mod DEPTH], handed out in order.
   typedef enum {M_IDLE, M_ACTIVE, M_DONE} mphase_t;
   mphase_t       ph        = M_IDLE;
   logic          model_on  = 1'b0;
   logic          exp_busy  = 1'b0;
   logic          exp_done  = 1'b0;
   logic          prev_stall = 1'b0;
   logic [DW-1:0] prev_data = '0;
   logic [DW-1:0] q [$];
   logic [AW-1:0] widx;
   int            left      = 0;
   int            accepted  = 0;

   always @(negedge clk) begin
      if (model_on) begin
         check("busy", DW'(busy), DW'(exp_busy));
         check("done", DW'(done), DW'(exp_done));
         if (out_valid) begin
            if (q.size() == 0) check("valid_without_word", DW'(out_valid), DW'(0));
            else               check("stream_data", out_data, q[0]);
         end
         if (prev_stall) check("stall_hold", out_data, prev_data);
         prev_stall = out_valid && !out_ready && !reset;
         prev_data  = out_data;
         if (reset) begin
            q.delete();
            ph         = M_IDLE;
            exp_busy   = 1'b0;
            exp_done   = 1'b0;
            prev_stall = 1'b0;
         end else begin
            case (ph)
               M_IDLE: if (start) begin
                  accepted = 0;
                  for (int i = 0; i < int'(count); i++) begin
                     widx = AW'(start_addr + AW'(i));
                     q.push_back(mem[widx]);
                  end
                  left = int'(count);
                  if (count == '0) begin
                     ph = M_DONE;
                     exp_done = 1'b1;
                  end else begin
                     ph = M_ACTIVE;
                     exp_busy = 1'b1;
                  end
               end
               M_ACTIVE: if (out_valid && out_ready) begin
                  if (q.size() > 0) void'(q.pop_front());
                  accepted++;
                  left--;
                  if (left == 0) begin
                     ph = M_DONE;
                     exp_busy = 1'b0;
                     exp_done = 1'b1;
                  end
               end
               M_DONE: begin
                  ph = M_IDLE;
                  exp_done = 1'b0;
               end
               default: ph = M_IDLE;
            endcase
         end
      end
   end

   // Called #1 after an edge; returns #1 after the edge that samples start.
   task automatic go(input logic [AW-1:0] sa, input logic [AW:0] cnt);
      start      = 1'b1;
      start_addr = sa;
      count      = cnt;
      @(posedge clk) #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int bound, input logic [5:0] pat);
      logic seen;
      seen = 1'b0;
      for (int c = 0; c < bound; c++) begin
         out_ready = pat[c % 6];
         @(posedge clk) #1;
         if (done) begin
            seen = 1'b1;
            break;
         end
      end
      check("done_within_bound", DW'(seen), DW'(1));
      out_ready = 1'b1;
      @(posedge clk) #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] = DW'(i + 100);
      reset = 1'b1; start = 1'b0; start_addr = '0; count = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", DW'(out_valid), DW'(0));
      check("rst_busy", DW'(busy), DW'(0));
      check("rst_done", DW'(done), DW'(0));
      check("rst_data", out_data, DW'(0));
      check("rst_raddr", DW'(read_address), DW'(0));
      reset = 1'b0;
      model_on = 1'b1;

      // Basic block: 102..105, first word two edges after start.
      go(4'd2, 5'd4);
      check("b_raddr0", DW'(read_address), DW'(2));
      check("b_valid_e0", DW'(out_valid), DW'(0));
      @(posedge clk) #1;
      check("b_valid_e1", DW'(out_valid), DW'(0));
      for (int k = 0; k < 4; k++) begin
         @(posedge clk) #1;
         check("b_valid", DW'(out_valid), DW'(1));
         check("b_word", out_data, DW'(102 + k));
      end
      @(posedge clk) #1;
      check("b_done", DW'(done), DW'(1));
      check("b_busy_at_done", DW'(busy), DW'(0));
      @(posedge clk) #1;
      check("b_done_drop", DW'(done), DW'(0));

      // Address wrap: 14,15,0,1.
      go(4'd14, 5'd4);
      check("w_raddr14", DW'(read_address), DW'(14));
      @(posedge clk) #1;
      check("w_raddr15", DW'(read_address), DW'(15));
      @(posedge clk) #1;
      check("w_raddr0", DW'(read_address), DW'(0));
      check("w_d114", out_data, DW'(114));
      @(posedge clk) #1;
      check("w_raddr1", DW'(read_address), DW'(1));
      check("w_d115", out_data, DW'(115));
      @(posedge clk) #1;
      check("w_d100", out_data, DW'(100));
      @(posedge clk) #1;
      check("w_d101", out_data, DW'(101));
      wait_done(20, 6'b111111);

      // Backpressure with ready pattern 1,0,0,1,0,1.
      go(4'd5, 5'd5);
      wait_done(80, 6'b101001);
      check("bp_accepted", DW'(accepted), DW'(5));

      // Empty block.
      go(4'd3, 5'd0);
      check("z_done", DW'(done), DW'(1));
      check("z_busy", DW'(busy), DW'(0));
      check("z_valid", DW'(out_valid), DW'(0));
      @(posedge clk) #1;
      check("z_done_drop", DW'(done), DW'(0));

      // Full-depth block.
      go(4'd7, 5'd16);
      wait_done(60, 6'b110110);
      check("full_accepted", DW'(accepted), DW'(16));

      // Abort after the second accept; reset also beats a concurrent start.
      go(4'd0, 5'd8);
      repeat (4) @(posedge clk) #1;
      check("ab_data_before", out_data, DW'(102));
      reset = 1'b1;
      start = 1'b1; start_addr = 4'd4; count = 5'd2;
      @(posedge clk) #1;
      reset = 1'b0;
      start = 1'b0;
      check("ab_valid", DW'(out_valid), DW'(0));
      check("ab_busy", DW'(busy), DW'(0));
      check("ab_raddr", DW'(read_address), DW'(0));
      repeat (2) @(posedge clk) #1;
      check("ab_still_idle", DW'(busy), DW'(0));
      go(4'd9, 5'd3);
      wait_done(30, 6'b111111);
      check("ab_accepted", DW'(accepted), DW'(3));

`ifdef CHECKSUM_EN
      mem[0] = DW'(32'h0F); mem[1] = DW'(32'hF0); mem[2] = DW'(32'hFF);
      go(4'd0, 5'd3);
      check("cs_clear", checksum, DW'(0));
      repeat (2) @(posedge clk) #1;
      check("cs_e2", checksum, DW'(0));
      @(posedge clk) #1;
      check("cs_1", checksum, DW'(32'h0F));
      @(posedge clk) #1;
      check("cs_2", checksum, DW'(32'hFF));
      @(posedge clk) #1;
      check("cs_3", checksum, DW'(32'h00));
      wait_done(20, 6'b111111);
      go(4'd1, 5'd1);
      wait_done(20, 6'b111111);
      check("cs_single", checksum, DW'(32'hF0));
      go(4'd0, 5'd2);
      check("cs_restart_clear", checksum, DW'(0));
      wait_done(20, 6'b111111);
`endif

      repeat (2) @(posedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_stream_reader.md
MEM_STREAM_READER -- requirements
Module: mem_stream_reader

Interface
REQ-001 SHALL have parameter data_width, default 32, word width of the attached RAM.
REQ-002 SHALL have parameter addr_width, default 4, address width of the attached RAM (depth 2**addr_width).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to stream a block; sampled only in IDLE.
REQ-006 SHALL have port start_addr  input  addr_width  first word address, sampled with start.
REQ-007 SHALL have port count  input  addr_width+1  words to read (0..2**addr_width), sampled with start.
REQ-008 SHALL have port read_address  output  addr_width  read address to the RAM, which returns mem[read_address] on dout one cycle later.
REQ-009 SHALL have port ram_dout  input  data_width  RAM read data.
REQ-010 SHALL have port out_data  output  data_width  streamed word.
REQ-011 SHALL have port out_valid  output  1  out_data holds a word.
REQ-012 SHALL have port out_ready  input  1  consumer accepts word when out_valid && out_ready.
REQ-013 SHALL have port busy  output  1  high in RUN and FLUSH.
REQ-014 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-015 SHALL implement states IDLE, RUN, FLUSH, DONE.
REQ-016 IDLE: start=1 SHALL latch addr=start_addr, remaining=count; go RUN if count!=0, else DONE.
REQ-017 RUN: read_address SHALL equal addr; a read is issued on a clock edge when remaining>0 and (buffered + in-flight - pop) <= 1, where pop = out_valid && out_ready that cycle.
REQ-018 Each issued read SHALL increment addr modulo 2**addr_width (wrap 2**addr_width-1 -> 0) and decrement remaining.
REQ-019 Word for a read issued at edge N SHALL be captured from ram_dout into a 2-entry FIFO at edge N+1; no word dropped or duplicated under any out_ready pattern.
REQ-020 out_valid SHALL be high whenever the FIFO is non-empty; out_data SHALL be the FIFO head and stay stable while out_valid && !out_ready.
REQ-021 With out_ready held high, first out_valid SHALL rise two edges after the edge sampling start, then one word per cycle, words in address order.
REQ-022 RUN -> FLUSH when remaining reaches 0; FLUSH -> DONE on the edge at which the last word is accepted.
REQ-023 DONE: done=1, busy=0 for exactly one cycle, then IDLE; start in RUN, FLUSH or DONE SHALL be ignored.
REQ-024 read_address SHALL hold its last value when no read is issued.

Reset
REQ-025 reset SHALL force IDLE, empty FIFO, clear in-flight tracking; out_valid=0, busy=0, done=0, out_data=0, read_address=0 after the edge.
REQ-026 reset mid-operation SHALL abort the stream; a RAM word in flight at reset SHALL be discarded.
REQ-027 reset SHALL take priority over start on the same edge.

Configuration
REQ-028 With CHECKSUM_EN defined, module SHALL add port checksum  output  data_width, XOR of all words accepted since the last accepted start; cleared to 0 by reset and by accepted start; updated on each accepting edge.
REQ-029 Without CHECKSUM_EN, port checksum and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-030 RAM mem[i]=i+100, start_addr=2, count=4, out_ready=1 -> out_data 102,103,104,105 on consecutive cycles, first two edges after start; done pulses once, one cycle after last accept.
REQ-031 start_addr=14, count=4, addr_width=4 -> read addresses 14,15,0,1; data 114,115,100,101.
REQ-032 count=5, out_ready toggled 1,0,0,1,0,1... -> all 5 words in order, none lost/duplicated, out_data stable during stalls, never >2 buffered.
REQ-033 count=0 -> done pulses the cycle after start, out_valid never asserts, busy stays 0.
REQ-034 reset asserted after second word accepted of count=8 -> out_valid=0, busy=0 next cycle; fresh start streams correctly from its own start_addr.
REQ-035 CHECKSUM_EN, words 0x0F,0xF0,0xFF -> checksum=0x00 after third accept; new start clears to 0.
